// File: rtl/config_broadcaster_if.sv
// Host table/control bus plus the outgoing reconfiguration bus
// (tracing/configId/configData) of the config broadcaster.
interface config_broadcaster_if #(
  parameter int NUM_ENTRIES     = 8,
  parameter int BYTES_PER_ENTRY = 4
);
  localparam int EW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int FW = $clog2(BYTES_PER_ENTRY + 1);
  localparam int NW = $clog2(NUM_ENTRIES + 1);

  logic          wr_en;
  logic [EW-1:0] wr_entry;
  logic [FW-1:0] wr_field;
  logic [7:0]    wr_data;
  logic [NW-1:0] num_entries;
  logic          start;
  logic          tracing;
  logic [7:0]    configId;
  logic [7:0]    configData;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_entry, wr_field, wr_data, num_entries, start,
    input  tracing, configId, configData, busy, done
  );

  modport slave (
    input  wr_en, wr_entry, wr_field, wr_data, num_entries, start,
    output tracing, configId, configData, busy, done
  );
endinterface

// File: rtl/config_broadcaster.sv
// Transmit side of the instrumentation reconfiguration bus. Streams a
// host-loaded table of (target ID, firmware bytes) entries to the receivers
// while tracing is dropped, then restores tracing and pulses done.
module config_broadcaster #(
  parameter int         NUM_ENTRIES     = 8,
  parameter int         BYTES_PER_ENTRY = 4,
  parameter logic [7:0] IDLE_ID         = 8'hFF
) (
  input logic                 clk,
  input logic                 reset,
  config_broadcaster_if.slave bus
);
  localparam int EW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int FW = $clog2(BYTES_PER_ENTRY + 1);
  localparam int NW = $clog2(NUM_ENTRIES + 1);
  localparam int KW = (BYTES_PER_ENTRY > 1) ? $clog2(BYTES_PER_ENTRY) : 1;

  typedef enum logic [1:0] {IDLE, LEAD, SEND, GAP} state_t;

  state_t        st, st_n;
  logic [7:0]    ids [NUM_ENTRIES];
  logic [7:0]    fw  [NUM_ENTRIES][BYTES_PER_ENTRY];
  logic [EW-1:0] entry, entry_n, hit;
  logic [KW-1:0] k, k_n, wr_k;
  logic [NW-1:0] n, n_n, base;
  logic          found;
  logic          tracing_q, tracing_n, busy_q, busy_n, done_q, done_n;
  logic [7:0]    cid_q, cid_n, cdata_q, cdata_n;

  // Firmware byte slot for fields 1..BYTES_PER_ENTRY
  assign wr_k = KW'(bus.wr_field - 1'b1);

  // Table load; frozen while a reconfiguration is in flight so the stream is coherent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ids[i] <= IDLE_ID;
        for (int j = 0; j < BYTES_PER_ENTRY; j++) fw[i][j] <= '0;
      end
    end else if (bus.wr_en && !busy_q) begin
      if (bus.wr_field == '0)
        ids[bus.wr_entry] <= bus.wr_data;
      else if (bus.wr_field <= FW'(BYTES_PER_ENTRY))
        fw[bus.wr_entry][wr_k] <= bus.wr_data;
    end
  end

  // Search starts at 0 after LEAD, or just past the entry that was just sent
  assign base = (st == GAP) ? NW'(entry) + 1'b1 : '0;

  // Lookahead: first sendable entry at or after base, so skipped entries cost no cycles
  always_comb begin
    found = 1'b0;
    hit   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!found && NW'(i) >= base && NW'(i) < n && ids[EW'(i)] != IDLE_ID) begin
        found = 1'b1;
        hit   = EW'(i);
      end
    end
  end

  // Next state and next (registered) bus values; defaults describe the IDLE bus
  always_comb begin
    st_n      = st;
    entry_n   = entry;
    k_n       = k;
    n_n       = n;
    tracing_n = 1'b1;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    cid_n     = IDLE_ID;
    cdata_n   = '0;
    unique case (st)
      IDLE: if (bus.start) begin
        st_n      = LEAD;
        entry_n   = '0;
        n_n       = (bus.num_entries > NW'(NUM_ENTRIES)) ? NW'(NUM_ENTRIES) : bus.num_entries;
        tracing_n = 1'b0;
        busy_n    = 1'b1;
      end
      LEAD, GAP: if (found) begin
        st_n      = SEND;
        entry_n   = hit;
        k_n       = '0;
        tracing_n = 1'b0;
        busy_n    = 1'b1;
        cid_n     = ids[hit];
        cdata_n   = fw[hit][KW'(0)];
      end else begin
        st_n   = IDLE;
        done_n = 1'b1;
      end
      SEND: begin
        tracing_n = 1'b0;
        busy_n    = 1'b1;
        if (k == KW'(BYTES_PER_ENTRY - 1)) begin
          // IDLE_ID for one cycle ends the receiver's match run
          st_n = GAP;
        end else begin
          k_n     = k + 1'b1;
          cid_n   = ids[entry];
          cdata_n = fw[entry][k_n];
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State and output registers; reset puts the bus back to tracing immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      entry     <= '0;
      k         <= '0;
      n         <= '0;
      tracing_q <= 1'b1;
      cid_q     <= IDLE_ID;
      cdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st        <= st_n;
      entry     <= entry_n;
      k         <= k_n;
      n         <= n_n;
      tracing_q <= tracing_n;
      cid_q     <= cid_n;
      cdata_q   <= cdata_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign bus.tracing    = tracing_q;
  assign bus.configId   = cid_q;
  assign bus.configData = cdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_config_broadcaster.sv
// Bench for config_broadcaster: a queue-based model expands each accepted
// start into the expected per-cycle bus sequence; a negedge process compares
// every cycle. A receiver model (ID 5) and a tracing-window monitor pin the
// model with hand-computed literals.
module tb_config_broadcaster;
  localparam int N = 8;
  localparam int B = 4;

  typedef struct packed {
    logic       tracing;
    logic [7:0] id;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } out_t;

  localparam out_t IDLE_OUT = {1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_broadcaster_if #(.NUM_ENTRIES(N), .BYTES_PER_ENTRY(B)) bus ();

  config_broadcaster #(.NUM_ENTRIES(N), .BYTES_PER_ENTRY(B), .IDLE_ID(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ids [N];
  logic [7:0] m_fw  [N][B];
  out_t       q[$];
  out_t       exp_cur = IDLE_OUT;
  out_t       exp_next;
  bit         chk_en = 1'b0;

  int         low_run = 0, last_win = 0, done_cnt = 0, rx_cnt = 0;
  logic [7:0] rx_fw [B];

  function automatic out_t mk(logic t, logic [7:0] id, logic [7:0] d, logic b, logic dn);
    return {t, id, d, b, dn};
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int e = 0; e < N; e++) begin
      m_ids[e] = 8'hFF;
      for (int j = 0; j < B; j++) m_fw[e][j] = 8'h00;
    end
  endtask

  // Expected bus value for the cycle after the coming clock edge
  task automatic model_step();
    int f;
    int nn;
    if (reset) begin
      model_reset();
      exp_next = IDLE_OUT;
      return;
    end
    f = int'(bus.wr_field);
    if (bus.wr_en && !exp_cur.busy) begin
      if (f == 0) m_ids[bus.wr_entry] = bus.wr_data;
      else if (f <= B) m_fw[bus.wr_entry][f-1] = bus.wr_data;
    end
    if (bus.start && !exp_cur.busy) begin
      nn = (int'(bus.num_entries) > N) ? N : int'(bus.num_entries);
      q.delete();
      q.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0));
      for (int e = 0; e < nn; e++) begin
        if (m_ids[e] != 8'hFF) begin
          for (int j = 0; j < B; j++) q.push_back(mk(1'b0, m_ids[e], m_fw[e][j], 1'b1, 1'b0));
          q.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0));
        end
      end
      q.push_back(mk(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1));
    end
    exp_next = (q.size() > 0) ? q.pop_front() : IDLE_OUT;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1 exp_cur = exp_next;
  endtask

  task automatic wr(int e, int f, int d);
    bus.wr_en = 1'b1; bus.wr_entry = 3'(e); bus.wr_field = 3'(f); bus.wr_data = 8'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic load(int e, int id, int b0, int b1, int b2, int b3);
    wr(e, 0, id); wr(e, 1, b0); wr(e, 2, b1); wr(e, 3, b2); wr(e, 4, b3);
  endtask

  task automatic go(int nn);
    bus.num_entries = 4'(nn); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic idle(int c);
    repeat (c) tick();
  endtask

  // Per-cycle compare, plus receiver (ID 5) and tracing-window monitors
  initial begin
    out_t act;
    forever begin
      @(negedge clk);
      act = {bus.tracing, bus.configId, bus.configData, bus.busy, bus.done};
      if (chk_en) begin
        checks++;
        if (act !== exp_cur) begin
          errors++;
          $display("FAIL bus_cycle t=%0t actual trc=%b id=%h data=%h busy=%b done=%b expected trc=%b id=%h data=%h busy=%b done=%b",
                   $time, act.tracing, act.id, act.data, act.busy, act.done,
                   exp_cur.tracing, exp_cur.id, exp_cur.data, exp_cur.busy, exp_cur.done);
        end
      end
      if (!reset) begin
        if (!bus.tracing && bus.configId == 8'h05) begin
          if (rx_cnt < B) rx_fw[rx_cnt] = bus.configData;
          rx_cnt++;
        end else rx_cnt = 0;
        if (!bus.tracing) low_run++;
        else if (low_run != 0) begin
          last_win = low_run;
          low_run  = 0;
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  initial begin
    int d0;
    bus.wr_en = 1'b0; bus.wr_entry = '0; bus.wr_field = '0; bus.wr_data = '0;
    bus.num_entries = '0; bus.start = 1'b0;
    for (int j = 0; j < B; j++) rx_fw[j] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tracing", int'(bus.tracing), 1);
    chk("rst_configId", int'(bus.configId), 255);
    chk("rst_configData", int'(bus.configData), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // T1: single entry
    load(0, 3, 8'h11, 8'h22, 8'h33, 8'h44);
    d0 = done_cnt;
    go(1); idle(10);
    chk("t1_window", last_win, 6);
    chk("t1_done", done_cnt - d0, 1);

    // T2: two entries, receiver ID 5 holds entry1 bytes
    load(1, 5, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    go(2); idle(14);
    chk("t2_window", last_win, 11);
    chk("t2_rx0", int'(rx_fw[0]), 8'hA1);
    chk("t2_rx1", int'(rx_fw[1]), 8'hA2);
    chk("t2_rx2", int'(rx_fw[2]), 8'hA3);
    chk("t2_rx3", int'(rx_fw[3]), 8'hA4);

    // T3: skipped entry
    wr(1, 0, 8'hFF);
    load(2, 7, 8'h71, 8'h72, 8'h73, 8'h74);
    go(3); idle(16);
    chk("t3_window", last_win, 11);

    // T4: n=0, then oversized n clamps to the table depth
    d0 = done_cnt;
    go(0); idle(4);
    chk("t4_window_n0", last_win, 1);
    chk("t4_done_n0", done_cnt - d0, 1);
    wr(1, 0, 5);
    for (int e = 3; e < N; e++) load(e, 8'h10 + e, e, e + 1, e + 2, e + 3);
    go(9); idle(45);
    chk("t4_window_n9", last_win, 41);

    // T5: write and start while busy are dropped
    d0 = done_cnt;
    go(1);
    wr(0, 0, 8'h20);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    idle(10);
    chk("t5_window", last_win, 6);
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_no_write_window", last_win, 6);

    // start held high re-triggers after done
    d0 = done_cnt;
    bus.num_entries = 4'd1; bus.start = 1'b1;
    repeat (8) tick();
    bus.start = 1'b0;
    idle(10);
    chk("t5_held_done", done_cnt - d0, 2);

    // Random traffic: writes (including invalid fields) and starts at any time
    for (int i = 0; i < 600; i++) begin
      bus.wr_en = ($urandom_range(0, 9) < 3);
      bus.wr_entry = 3'($urandom_range(0, N - 1));
      bus.wr_field = 3'($urandom_range(0, 7));
      bus.wr_data = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      bus.start = ($urandom_range(0, 9) == 0);
      bus.num_entries = 4'($urandom_range(0, 15));
      tick();
    end
    bus.wr_en = 1'b0; bus.start = 1'b0;
    idle(60);

    // T6: reset during the second SEND cycle
    load(0, 3, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
    go(1); tick(); tick();
    chk("t6_send2_data", int'(bus.configData), 8'h6B);
    #2 reset = 1'b1;
    model_reset();
    exp_cur = IDLE_OUT;
    #1;
    chk("t6_tracing", int'(bus.tracing), 1);
    chk("t6_configId", int'(bus.configId), 255);
    chk("t6_configData", int'(bus.configData), 0);
    chk("t6_busy", int'(bus.busy), 0);
    tick();
    reset = 1'b0;
    low_run = 0;
    go(8); idle(4);
    chk("t6_table_cleared", last_win, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
